uart_rx_bit_sampler: RTL
========================

Name: uart_rx_bit_sampler

Overview:
Front end of the UART receiver. It synchronises the asynchronous rx line, generates the oversampling tick from a programmable divisor, detects and qualifies start bits, and majority-votes each bit at mid-bit. It drives bit_valid, bit_sample and start_detected into the downstream uart_rx_state_machine. It takes frame_active back from that block to know when the frame has ended.

Parameters:
OVERSAMPLE, 16, ticks per bit period; even, >= 8
SYNC_STAGES, 2, rx synchroniser depth; >= 2
DIV_WIDTH, 16, width of baud_div

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
rx_in  in  1  asynchronous serial line; idle high
rx_enable  in  1  receiver enable
baud_div  in  DIV_WIDTH  clk cycles per oversample tick, minus 1
frame_active  in  1  from state machine; high while a frame is in progress
bit_valid  out  1  one-clk pulse; bit_sample is valid
bit_sample  out  1  majority-voted bit value
start_detected  out  1  one-clk pulse; start bit confirmed
false_start  out  1  one-clk pulse; start bit rejected as a glitch
rx_sync  out  1  synchronised rx line (status/debug)

Behaviour:
- Reset (async): synchroniser flops and rx_prev = 1; rx_sync = 1; prescaler = 0; tc = 0; state = IDLE; bit_valid, start_detected, false_start = 0; bit_sample = 1.
- rx_enable = 0 (synchronous):
  - Force IDLE and clear prescaler, tc and vote registers.
  - All pulse outputs are held at 0.
  - The synchroniser keeps running.
- Prescaler:
  - Counts 0..baud_div; tick = 1 for one clk when prescaler == baud_div, then reloads to 0.
  - Cleared on start-edge detection so ticks align to the edge.
  - A new baud_div value is used from the next compare.
  - baud_div = 0 gives a tick every clk.
- tc (bit-phase counter, 0..OVERSAMPLE-1):
  - Cleared with the prescaler.
  - Increments on each tick and wraps to 0.
  - M = OVERSAMPLE/2.
- Vote: on a tick with tc ∈ {M-1, M, M+1}, capture rx_sync into v[0..2]. Result = majority(v).
- States:
  - IDLE: hunt for a falling edge (rx_prev = 1, rx_sync = 0). On an edge, clear prescaler and tc, go to START_CHK. A line that is already low on entry does not trigger.
  - START_CHK: after the tc = M+1 sample, register the vote. Vote 0 → start_detected pulse next clk, go to BITS. Vote 1 → false_start pulse next clk, go to IDLE.
  - BITS: tc continues from the start bit with no realignment. After each tc = M+1 sample, pulse bit_valid next clk and update bit_sample in the same clk; bit_sample holds until the next update.
- BITS exit:
  - Go to IDLE when frame_active = 0, but not in the first 2 clks after start_detected (state machine registration latency).
  - After the last stop-bit bit_valid, frame_active falls one clk later, so hunting resumes mid-stop-bit and back-to-back frames are caught.
- Simultaneous events:
  - rx_enable = 0 overrides everything.
  - A frame_active fall takes priority over a pending vote in the same clk; no bit_valid is produced.
- Reset mid-frame: immediate return to IDLE; no partial pulses afterwards.
- Outputs are registered; no combinational path from rx_in or frame_active to any output.
- Timing: with T = baud_div + 1, start_detected occurs (M+2)·T + 1 clk after edge detection. Each bit_valid follows OVERSAMPLE·T clk later.

Decomposition:
- Shared package uart_rx_pkg: sampler state enum (IDLE, START_CHK, BITS), default OVERSAMPLE, majority function.
- Sub-module uart_rx_baud_tick: the prescaler, with ports clk, rst_n, clear, baud_div, tick.

Test Plan:
- OVERSAMPLE = 16, baud_div = 3, clean 1→0 edge → start_detected exactly 41 clk after edge detection; no false_start.
- rx low for 8 clk then high → false_start pulse once; no start_detected; next valid edge is still accepted.
- 8N1 frame 0xA5 (LSB first), frame_active modelled as the state machine does → 9 bit_valid pulses 64 clk apart, bit_sample sequence 1,0,1,0,0,1,0,1,1; back-to-back second frame 0x3C is detected correctly.
- One-tick inverted glitch at tc = M on data bit 3 → bit_sample unchanged (majority vote holds).
- rx_enable deasserted at bit 4 → no further pulses, state = IDLE; separately, rst_n asserted mid-frame → all outputs at reset values immediately.
- baud_div = 0, OVERSAMPLE = 8 → bit_valid every 8 clk; a mid-frame baud_div change takes effect at the next prescaler compare.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver front end.
//   - samp_state_e : bit-sampler state encoding (IDLE, START_CHK, BITS)
//   - OVERSAMPLE_DEF : default number of oversample ticks per bit period
//   - maj3() : 2-of-3 majority vote over the three mid-bit samples
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    BITS      = 2'd2
  } samp_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler_if.sv
// Sampler <-> receive state machine link.
//   bit_valid      : one-clk pulse, bit_sample is valid
//   bit_sample     : majority-voted bit value
//   start_detected : one-clk pulse, start bit confirmed
//   false_start    : one-clk pulse, start bit rejected as a glitch
//   frame_active   : from the state machine, high while a frame is in progress
// master = bit sampler, slave = state machine.
interface uart_rx_bit_sampler_if;

  logic bit_valid;
  logic bit_sample;
  logic start_detected;
  logic false_start;
  logic frame_active;

  modport master (
    output bit_valid,
    output bit_sample,
    output start_detected,
    output false_start,
    input  frame_active
  );

  modport slave (
    input  bit_valid,
    input  bit_sample,
    input  start_detected,
    input  false_start,
    output frame_active
  );

endinterface

// File: rtl/uart_rx_baud_tick.sv
// Oversample prescaler: counts 0..baud_div and flags a one-clk tick on the
// terminal count, then reloads to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : holds the counter at 0 and suppresses the tick
//   baud_div   : clk cycles per tick minus 1 (0 = tick every clk)
//   tick       : one-clk oversample tick
module uart_rx_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 hit_s;

  // Terminal-count compare and next count. baud_div is read live, so a new
  // value applies at the very next compare; >= lets a reduced divisor that is
  // already below the running count reload immediately instead of wrapping.
  always_comb begin
    hit_s = (cnt_q >= baud_div);
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {DIV_WIDTH{1'b0}};
    end else if (hit_s) begin
      tick  = 1'b1;
      cnt_d = {DIV_WIDTH{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {DIV_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: rx synchroniser, oversample tick generation,
// start-bit qualification and mid-bit majority voting.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_in      : asynchronous serial line (idle high)
//   rx_enable  : receiver enable; low forces IDLE and silences all pulses
//   baud_div   : clk cycles per oversample tick minus 1
//   bus        : master side of the link to the receive state machine
//   rx_sync    : synchronised rx line
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 rx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  uart_rx_bit_sampler_if.master bus,
  output logic                 rx_sync
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int M    = OVERSAMPLE / 2;
  localparam logic [TC_W-1:0] TC_ZERO = TC_W'(0);
  localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0] TC_VM1  = TC_W'(M - 1);
  localparam logic [TC_W-1:0] TC_VM   = TC_W'(M);
  localparam logic [TC_W-1:0] TC_VP1  = TC_W'(M + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_sync_s;
  logic                   edge_s;
  logic                   tick_s;
  logic                   clear_s;

  samp_state_e     state_q, state_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic [2:0]      vote_q, vote_d;
  logic            vote_pend_q, vote_pend_d;
  logic [1:0]      guard_q, guard_d;
  logic            bit_valid_q, bit_valid_d;
  logic            bit_sample_q, bit_sample_d;
  logic            start_det_q, start_det_d;
  logic            false_start_q, false_start_d;

  assign rx_sync_s = sync_q[SYNC_STAGES-1];
  assign edge_s    = rx_prev_q & ~rx_sync_s;
  // Prescaler idles at 0 while hunting, so the first tick after an edge
  // lands exactly T clks later.
  assign clear_s   = ~rx_enable | (state_q == IDLE);

  uart_rx_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .baud_div (baud_div),
    .tick     (tick_s)
  );

  // rx synchroniser and previous-value flop for falling-edge detection;
  // runs regardless of rx_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{1'b1}};
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_sync_s;
    end
  end

  // Next-state, phase counter, vote capture and output pulse decode.
  always_comb begin
    state_d       = state_q;
    tc_d          = tc_q;
    vote_d        = vote_q;
    vote_pend_d   = vote_pend_q;
    guard_d       = guard_q;
    bit_valid_d   = 1'b0;
    bit_sample_d  = bit_sample_q;
    start_det_d   = 1'b0;
    false_start_d = 1'b0;

    // Bit-phase counter and the three mid-bit samples around tc = M.
    // vote_pend marks that the third sample was taken; the decision is
    // registered one clk later.
    if (tick_s && (state_q != IDLE)) begin
      if (tc_q == TC_LAST) begin
        tc_d = TC_ZERO;
      end else begin
        tc_d = tc_q + TC_ONE;
      end
      case (tc_q)
        TC_VM1: vote_d[0] = rx_sync_s;
        TC_VM:  vote_d[1] = rx_sync_s;
        TC_VP1: begin
          vote_d[2]   = rx_sync_s;
          vote_pend_d = 1'b1;
        end
        default: vote_d = vote_q;
      endcase
    end else begin
      tc_d = tc_q;
    end

    case (state_q)
      IDLE: begin
        tc_d        = TC_ZERO;
        vote_d      = 3'b000;
        vote_pend_d = 1'b0;
        guard_d     = 2'd0;
        if (edge_s) begin
          state_d = START_CHK;
        end else begin
          state_d = IDLE;
        end
      end
      START_CHK: begin
        if (vote_pend_q) begin
          vote_pend_d = 1'b0;
          if (maj3(vote_q)) begin
            false_start_d = 1'b1;
            state_d       = IDLE;
          end else begin
            start_det_d = 1'b1;
            // The state machine needs two clks to raise frame_active.
            guard_d     = 2'd2;
            state_d     = BITS;
          end
        end else begin
          state_d = START_CHK;
        end
      end
      BITS: begin
        if ((guard_q == 2'd0) && !bus.frame_active) begin
          // Frame end wins over a vote waiting to be reported.
          state_d     = IDLE;
          tc_d        = TC_ZERO;
          vote_d      = 3'b000;
          vote_pend_d = 1'b0;
        end else begin
          if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
          end else begin
            guard_d = guard_q;
          end
          if (vote_pend_q) begin
            vote_pend_d  = 1'b0;
            bit_valid_d  = 1'b1;
            bit_sample_d = maj3(vote_q);
          end else begin
            bit_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        tc_d        = TC_ZERO;
        vote_d      = 3'b000;
        vote_pend_d = 1'b0;
        guard_d     = 2'd0;
      end
    endcase

    if (!rx_enable) begin
      state_d       = IDLE;
      tc_d          = TC_ZERO;
      vote_d        = 3'b000;
      vote_pend_d   = 1'b0;
      guard_d       = 2'd0;
      bit_valid_d   = 1'b0;
      start_det_d   = 1'b0;
      false_start_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Sampler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tc_q          <= TC_ZERO;
      vote_q        <= 3'b000;
      vote_pend_q   <= 1'b0;
      guard_q       <= 2'd0;
      bit_valid_q   <= 1'b0;
      bit_sample_q  <= 1'b1;
      start_det_q   <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tc_q          <= tc_d;
      vote_q        <= vote_d;
      vote_pend_q   <= vote_pend_d;
      guard_q       <= guard_d;
      bit_valid_q   <= bit_valid_d;
      bit_sample_q  <= bit_sample_d;
      start_det_q   <= start_det_d;
      false_start_q <= false_start_d;
    end
  end

  assign bus.bit_valid      = bit_valid_q;
  assign bus.bit_sample     = bit_sample_q;
  assign bus.start_detected = start_det_q;
  assign bus.false_start    = false_start_q;
  assign rx_sync            = rx_sync_s;

endmodule
